// File: rtl/rr_arbiter_fsm_if.sv
// rr_arbiter_fsm_if: request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter_fsm_if #(parameter int N = 4);
    logic [N-1:0]         req;
    logic [N-1:0]         done;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] grant_id;
    logic                 busy;
    logic                 timeout;
    modport master (output req, done, input grant, grant_id, busy, timeout);
    modport slave  (input req, done, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: three-state Moore round-robin arbiter with a hold timer and a one-cycle dead gap.
module rr_arbiter_fsm #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rstn,
    rr_arbiter_fsm_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [N-1:0] ONE   = N'(1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic [CW-1:0] r_cnt;
    logic          r_forced;

    logic [2*N-1:0] w_dbl;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;
    logic [IW-1:0]  w_pick;
    logic [IW-1:0]  w_next;
    logic           w_any;
    logic           w_limit;
    logic           w_release;
    logic           w_forced;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit is the winner's offset.
    always_comb begin
        w_dbl = {bus.req, bus.req} >> r_ptr;
        w_off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_dbl[i]) w_off = IW'(i);
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    end

    assign w_any     = |bus.req;
    assign w_next    = (r_id == IW'(N - 1)) ? '0 : r_id + 1'b1;
    assign w_limit   = (r_cnt == CW'(MAX_HOLD - 1));
    assign w_release = bus.done[r_id] | ~bus.req[r_id] | w_limit;
    assign w_forced  = w_limit & bus.req[r_id] & ~bus.done[r_id];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_forced <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_id    <= w_pick;
                        r_cnt   <= '0;
                    end
                S_GRANT:
                    if (w_release) begin
                        r_state  <= S_GAP;
                        r_ptr    <= w_next;
                        r_forced <= w_forced;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant    = (r_state == S_GRANT) ? (ONE << r_id) : '0;
    assign bus.busy     = (r_state == S_GRANT);
    assign bus.timeout  = (r_state == S_GAP) & r_forced;
    assign bus.grant_id = r_id;
endmodule
